// File: rtl/fp_mul_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_seq
//
// Multi-cycle IEEE-754-style floating-point multiplier with parametrised
// exponent and fraction widths. The significand product is built LSB-first,
// one shift-add partial product per clock, then a single normalise/round
// cycle produces the packed result and exception flags. Special operands
// (zero, infinity, NaN) bypass the multiplier and complete in one cycle.
// Denormal inputs are flushed to zero; results that would be denormal are
// flushed to signed zero.
//
// Parameters:
//   EXP_W   exponent field width (>= 3), bias = 2^(EXP_W-1)-1
//   FRAC_W  stored fraction width (>= 2), significand has a hidden 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       operands {sign, exp, frac}
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer accepts result
//   result     product {sign, exp, frac}
//   flags      {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_mul_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [3:0]              flags
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W + 1);

    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SIG_W - 1);
    localparam logic signed [EXP_W+1:0] BIAS_E  = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0]           QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                     state_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [W-1:0]               result_q;
    logic [3:0]                 flags_q;
    logic [SIG_W-1:0]           sigA_q;
    logic [SIG_W-1:0]           sigB_q;
    logic [PROD_W-1:0]          acc_q;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [EXP_W+1:0]    expSum_q;
    logic                       sign_q;

    // -----------------------------------------------------------------------
    // Operand decode and classification
    // -----------------------------------------------------------------------
    logic               signA, signB, prodSign;
    logic [EXP_W-1:0]   expA, expB;
    logic [FRAC_W-1:0]  fracA, fracB;
    logic               zeroA, zeroB, infA, infB, nanA, nanB;

    assign signA    = a[W-1];
    assign signB    = b[W-1];
    assign expA     = a[W-2:FRAC_W];
    assign expB     = b[W-2:FRAC_W];
    assign fracA    = a[FRAC_W-1:0];
    assign fracB    = b[FRAC_W-1:0];
    assign prodSign = signA ^ signB;

    // exp == 0 covers both true zero and denormals, which are flushed.
    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);
    assign infA  = (&expA) && (fracA == '0);
    assign infB  = (&expB) && (fracB == '0);
    assign nanA  = (&expA) && (fracA != '0);
    assign nanB  = (&expB) && (fracB != '0);

    // -----------------------------------------------------------------------
    // Special-case result, resolved in priority order NaN, inf, zero
    // -----------------------------------------------------------------------
    logic           isSpecial;
    logic [W-1:0]   specialResult;
    logic [3:0]     specialFlags;
    logic           infTimesZero;

    assign infTimesZero = (infA && zeroB) || (zeroA && infB);

    always_comb begin
        isSpecial     = 1'b1;
        specialResult = '0;
        specialFlags  = '0;
        if (nanA || nanB || infTimesZero) begin
            specialResult   = QNAN;
            specialFlags[3] = infTimesZero;
        end else if (infA || infB) begin
            specialResult = {prodSign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (zeroA || zeroB) begin
            specialResult = {prodSign, {(W-1){1'b0}}};
        end else begin
            isSpecial = 1'b0;
        end
    end

    // Biased exponent of the product before normalisation; two guard bits
    // keep the sum and a negative (underflowing) value representable.
    logic signed [EXP_W+1:0] expSumIn;

    assign expSumIn = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_E;

    // -----------------------------------------------------------------------
    // Shift-add step: add sigA into the top half when the current multiplier
    // bit is set, then shift the whole accumulator right by one. After SIG_W
    // steps the accumulator holds the exact product, and the bits shifted out
    // are always zero.
    // -----------------------------------------------------------------------
    logic [SIG_W:0]     mulSum;
    logic [PROD_W-1:0]  acc_d;

    always_comb begin
        mulSum = {1'b0, acc_q[PROD_W-1:SIG_W]} + (sigB_q[0] ? {1'b0, sigA_q} : '0);
        acc_d  = {mulSum, acc_q[SIG_W-1:1]};
    end

    // -----------------------------------------------------------------------
    // Normalise, round to nearest even, and range check
    // -----------------------------------------------------------------------
    logic                       normShift;
    logic [SIG_W-1:0]           mant;
    logic                       guardBit;
    logic                       stickyBit;
    logic                       roundUp;
    logic [FRAC_W:0]            fracRnd;
    logic                       roundCarry;
    logic [EXP_W+1:0]           expIncr;
    logic signed [EXP_W+1:0]    expFinal;
    logic                       isOverflow;
    logic                       isUnderflow;
    logic                       inexactN;
    logic [W-1:0]               result_d;
    logic [3:0]                 flags_d;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); the MSB says which.
        normShift = acc_q[PROD_W-1];
        if (normShift) begin
            mant      = acc_q[PROD_W-1:SIG_W];
            guardBit  = acc_q[SIG_W-1];
            stickyBit = |acc_q[SIG_W-2:0];
        end else begin
            mant      = acc_q[PROD_W-2:SIG_W-1];
            guardBit  = acc_q[SIG_W-2];
            stickyBit = |acc_q[SIG_W-3:0];
        end

        roundUp = guardBit & (stickyBit | mant[0]);

        // Rounding only touches the stored fraction; a carry out of it turns
        // 1.11..1 into 10.00..0, whose stored fraction is already all zeros.
        fracRnd    = {1'b0, mant[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, roundUp};
        roundCarry = fracRnd[FRAC_W] & mant[FRAC_W];

        expIncr      = '0;
        expIncr[1:0] = {1'b0, normShift} + {1'b0, roundCarry};
        expFinal     = expSum_q + $signed(expIncr);

        isUnderflow = expFinal[EXP_W+1] || (expFinal == '0);
        isOverflow  = !expFinal[EXP_W+1] && (expFinal[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
        inexactN    = guardBit | stickyBit;

        if (isOverflow) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags_d  = 4'b0101;
        end else if (isUnderflow) begin
            result_d = {sign_q, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end else begin
            result_d = {sign_q, expFinal[EXP_W-1:0], fracRnd[FRAC_W-1:0]};
            flags_d  = {3'b000, inexactN};
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers. Handshake outputs are registered so
    // in_ready is high only in IDLE and out_valid only in DONE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            sigA_q      <= '0;
            sigB_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            expSum_q    <= '0;
            sign_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= prodSign;
                        if (isSpecial) begin
                            result_q    <= specialResult;
                            flags_q     <= specialFlags;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            flags_q  <= '0;
                            sigA_q   <= {1'b1, fracA};
                            sigB_q   <= {1'b1, fracB};
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            expSum_q <= expSumIn;
                            state_q  <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    sigB_q <= sigB_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    result_q    <= result_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // No accept in the handshake cycle; in_ready rises next cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_seq
//
// Directed-vector bench for fp_mul_seq. One instance uses the default single
// precision widths; a second instance uses EXP_W=5, FRAC_W=10 (half
// precision). Expected results, flags and latencies are hand-computed.
// ---------------------------------------------------------------------------
module tb_fp_mul_seq;

    logic        clk;
    logic        rst_n;

    // Single-precision instance signals
    logic        inValid;
    logic        inReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        outReady;
    logic [31:0] res;
    logic [3:0]  flg;

    // Half-precision instance signals
    logic        hInValid;
    logic        hInReady;
    logic [15:0] hA;
    logic [15:0] hB;
    logic        hOutValid;
    logic        hOutReady;
    logic [15:0] hRes;
    logic [3:0]  hFlg;

    int checks;
    int errors;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (res),
        .flags     (flg)
    );

    fp_mul_seq #(
        .EXP_W  (5),
        .FRAC_W (10)
    ) dutHalf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (hInValid),
        .in_ready  (hInReady),
        .a         (hA),
        .b         (hB),
        .out_valid (hOutValid),
        .out_ready (hOutReady),
        .result    (hRes),
        .flags     (hFlg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one operation on the single-precision instance, measures the
    // latency to out_valid, checks result/flags, optionally holds out_ready
    // low for a while, then completes the output handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] av,
                                 input logic [31:0] bv, input int expLat,
                                 input logic [31:0] expRes, input logic [3:0] expFlags,
                                 input int holdCycles);
        int   lat;
        logic seen;
        @(negedge clk);
        checkOutput({tag, " in_ready before accept"}, 32'(inReady), 32'd1);
        opA     = av;
        opB     = bv;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput({tag, " in_ready after accept"}, 32'(inReady), 32'd0);
        lat  = 1;
        seen = outValid;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = outValid;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " result"}, res, expRes);
        checkOutput({tag, " flags"}, 32'(flg), 32'(expFlags));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, " hold out_valid"}, 32'(outValid), 32'd1);
            checkOutput({tag, " hold in_ready"}, 32'(inReady), 32'd0);
            checkOutput({tag, " hold result"}, res, expRes);
            checkOutput({tag, " hold flags"}, 32'(flg), 32'(expFlags));
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, " out_valid after handshake"}, 32'(outValid), 32'd0);
        checkOutput({tag, " in_ready after handshake"}, 32'(inReady), 32'd1);
    endtask

    initial begin
        int lat;
        int rises;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        inValid   = 1'b0;
        opA       = '0;
        opB       = '0;
        outReady  = 1'b0;
        hInValid  = 1'b0;
        hA        = '0;
        hB        = '0;
        hOutReady = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset result", res, 32'h0);
        checkOutput("reset flags", 32'(flg), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic product and rounding
        applyStimulus("1.5x2", 32'h3FC00000, 32'h40000000, 26, 32'h40400000, 4'b0000, 0);
        applyStimulus("tie even", 32'h3F800800, 32'h3F800800, 26, 32'h3F801000, 4'b0001, 0);
        applyStimulus("below half", 32'h3F800001, 32'h3F800001, 26, 32'h3F800002, 4'b0001, 0);

        // Special cases
        applyStimulus("inf x zero", 32'h7F800000, 32'h00000000, 1, 32'h7FC00000, 4'b1000, 0);
        applyStimulus("nan x one", 32'h7FC00001, 32'h3F800000, 1, 32'h7FC00000, 4'b0000, 0);
        applyStimulus("-inf x 2", 32'hFF800000, 32'h40000000, 1, 32'hFF800000, 4'b0000, 0);

        // Range limits
        applyStimulus("overflow", 32'h7F000000, 32'h40000000, 26, 32'h7F800000, 4'b0101, 0);
        applyStimulus("underflow", 32'h00800000, 32'h3F000000, 26, 32'h00000000, 4'b0011, 0);
        applyStimulus("-0 x 1", 32'h80000000, 32'h3F800000, 1, 32'h80000000, 4'b0000, 0);

        // Backpressure
        applyStimulus("backpressure", 32'h3FC00000, 32'hC0000000, 26, 32'hC0400000, 4'b0000, 10);

        // Mid-operation reset during MUL cycle 5
        @(negedge clk);
        opA     = 32'h3F800000;
        opB     = 32'h3F800000;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset in_ready", 32'(inReady), 32'd1);
        checkOutput("midreset out_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (outValid) rises++;
        end
        checkOutput("midreset no out_valid", 32'(rises), 32'd0);
        checkOutput("midreset idle in_ready", 32'(inReady), 32'd1);

        // Half-precision instance: 1.0 x 2.0
        @(negedge clk);
        checkOutput("half in_ready", 32'(hInReady), 32'd1);
        hA       = 16'h3C00;
        hB       = 16'h4000;
        hInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hInValid = 1'b0;
        lat = 1;
        while (!hOutValid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("half latency", 32'(lat), 32'd13);
        checkOutput("half result", 32'(hRes), 32'h4000);
        checkOutput("half flags", 32'(hFlg), 32'h0);
        hOutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hOutReady = 1'b0;
        checkOutput("half in_ready after handshake", 32'(hInReady), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
